// File: rtl/dps_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dps_uart_tx_arbiter
// Brief    : Round-robin, message-granular arbiter sharing one dps_uart TX path
//            between P_N byte-stream requesters, with idle-owner timeout release.
// Revision : 1.0 - initial release
// ============================================================================
module dps_uart_tx_arbiter #(
    parameter int P_N       = 4,
    parameter int P_N_BITS  = 2,
    parameter int P_TIMEOUT = 1024
) (
    input  logic                iCLOCK,
    input  logic                iRESET_SYNC,
    input  logic [P_N-1:0]      iREQ_VALID,
    input  logic [P_N*8-1:0]    iREQ_DATA,
    input  logic [P_N-1:0]      iREQ_LAST,
    output logic [P_N-1:0]      oREQ_ACK,
    output logic [P_N-1:0]      oGRANT,
    output logic [P_N_BITS-1:0] oOWNER,
    output logic                oACTIVE,
    output logic                oTIMEOUT,
    output logic                oUART_TX_REQ,
    output logic [7:0]          oUART_TX_DATA,
    input  logic                iUART_TX_BUSY
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam logic [16:0]         c_TIMEOUT_LIMIT = 17'(P_TIMEOUT - 1);
    localparam logic [P_N_BITS-1:0] c_OWNER_RESET   = P_N_BITS'(P_N - 1);
    localparam logic [P_N-1:0]      c_GRANT_ONE     = {{(P_N-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_stateNext;
    logic [P_N-1:0]      r_grant;
    logic [P_N-1:0]      w_grantNext;
    logic [P_N_BITS-1:0] r_owner;
    logic [P_N_BITS-1:0] w_ownerNext;
    logic [15:0]         r_cnt;
    logic [15:0]         w_cntNext;
    logic                r_timeout;
    logic                w_timeoutNext;

    logic                w_ownerValid;
    logic                w_ownerLast;
    logic [7:0]          w_ownerData;
    logic                w_accept;
    logic                w_found;
    logic [P_N_BITS-1:0] w_sel;
    logic [16:0]         w_cntInc;

    assign w_ownerValid = iREQ_VALID[r_owner];
    assign w_ownerLast  = iREQ_LAST[r_owner];
    assign w_ownerData  = iREQ_DATA[r_owner*8 +: 8];
    assign w_accept     = (r_state == ST_XFER) && w_ownerValid && !iUART_TX_BUSY;
    assign w_cntInc     = {1'b0, r_cnt} + 17'd1;

    // Search starts one past the last owner so the previous owner ranks lowest.
    always_comb begin
        logic [P_N_BITS-1:0] idx;
        w_sel   = r_owner;
        w_found = 1'b0;
        idx     = '0;
        for (int k = 1; k <= P_N; k++) begin
            idx = r_owner + P_N_BITS'(k);
            if (!w_found && iREQ_VALID[idx]) begin
                w_sel   = idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_grantNext   = r_grant;
        w_ownerNext   = r_owner;
        w_cntNext     = r_cnt;
        w_timeoutNext = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_stateNext = ST_XFER;
                    w_grantNext = c_GRANT_ONE << w_sel;
                    w_ownerNext = w_sel;
                    w_cntNext   = '0;
                end
            end
            ST_XFER: begin
                if (w_accept) begin
                    w_cntNext = '0;
                    if (w_ownerLast) begin
                        w_stateNext = ST_IDLE;
                        w_grantNext = '0;
                    end
                end else if (!w_ownerValid) begin
                    // Only an absent owner byte ages the counter; FIFO-full stalls do not.
                    if (w_cntInc >= c_TIMEOUT_LIMIT) begin
                        w_stateNext   = ST_IDLE;
                        w_grantNext   = '0;
                        w_cntNext     = '0;
                        w_timeoutNext = 1'b1;
                    end else begin
                        w_cntNext = w_cntInc[15:0];
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_grantNext = '0;
            end
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_owner   <= c_OWNER_RESET;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_grant   <= w_grantNext;
            r_owner   <= w_ownerNext;
            r_cnt     <= w_cntNext;
            r_timeout <= w_timeoutNext;
        end
    end

    assign oGRANT        = r_grant;
    assign oOWNER        = r_owner;
    assign oACTIVE       = (r_state == ST_XFER);
    assign oTIMEOUT      = r_timeout;
    assign oUART_TX_REQ  = w_accept;
    assign oREQ_ACK      = w_accept ? r_grant : '0;
    assign oUART_TX_DATA = (r_state == ST_XFER) ? w_ownerData : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_dps_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dps_uart_tx_arbiter
// Brief    : Scoreboard bench for dps_uart_tx_arbiter (4 requesters, timeout 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dps_uart_tx_arbiter;

    localparam int c_N       = 4;
    localparam int c_TIMEOUT = 16;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic [c_N-1:0]   reqValid = '0;
    logic [c_N*8-1:0] reqData  = '0;
    logic [c_N-1:0]   reqLast  = '0;
    logic             busy     = 1'b0;

    logic [c_N-1:0]   oREQ_ACK;
    logic [c_N-1:0]   oGRANT;
    logic [1:0]       oOWNER;
    logic             oACTIVE;
    logic             oTIMEOUT;
    logic             oUART_TX_REQ;
    logic [7:0]       oUART_TX_DATA;

    int checkCount = 0;
    int errorCount = 0;

    logic [8:0] reqQ [c_N][$];
    logic [7:0] expQ [$];
    int         grantLog [$];
    int         wrCycles [$];
    logic [c_N-1:0] ackLatched = '0;
    int  gapRun   [c_N] = '{default: 0};
    int  ackTotal [c_N] = '{default: 0};
    int  ackCycle [c_N] = '{default: 0};
    bit  randGaps = 1'b0;
    bit  randBusy = 1'b0;
    logic busyCmd = 1'b0;
    int  cyc = 0;
    int  timeoutCount = 0;
    int  timeoutCycle = -1;
    int  grantCycle = -1;
    bit  pending = 1'b0;
    int  expOwner = 0;
    int  modelLast = c_N - 1;

    dps_uart_tx_arbiter #(
        .P_N       (c_N),
        .P_N_BITS  (2),
        .P_TIMEOUT (c_TIMEOUT)
    ) dut (
        .iCLOCK        (clk),
        .iRESET_SYNC   (rst),
        .iREQ_VALID    (reqValid),
        .iREQ_DATA     (reqData),
        .iREQ_LAST     (reqLast),
        .oREQ_ACK      (oREQ_ACK),
        .oGRANT        (oGRANT),
        .oOWNER        (oOWNER),
        .oACTIVE       (oACTIVE),
        .oTIMEOUT      (oTIMEOUT),
        .oUART_TX_REQ  (oUART_TX_REQ),
        .oUART_TX_DATA (oUART_TX_DATA),
        .iUART_TX_BUSY (busy)
    );

    always #5 clk = ~clk;

    task automatic chkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int rrPick(input int last, input logic [c_N-1:0] v);
        for (int k = 1; k <= c_N; k++) begin
            if (v[(last + k) % c_N]) return (last + k) % c_N;
        end
        return -1;
    endfunction

    function automatic bit anyQueued();
        for (int i = 0; i < c_N; i++) begin
            if (reqQ[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic loadMsg(input int r, input int len, input logic [7:0] first);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = first + 8'(k);
            reqQ[r].push_back({(k == len - 1) ? 1'b1 : 1'b0, b});
        end
    endtask

    task automatic driveInputs();
        bit v;
        for (int i = 0; i < c_N; i++) begin
            if (ackLatched[i] && reqQ[i].size() != 0) void'(reqQ[i].pop_front());
        end
        ackLatched = '0;
        for (int i = 0; i < c_N; i++) begin
            if (randGaps && gapRun[i] < 2 && $urandom_range(3) == 0) begin
                v = 1'b0;
                gapRun[i]++;
            end else begin
                v = (reqQ[i].size() != 0);
                gapRun[i] = 0;
            end
            reqValid[i] = v;
            reqData[i*8 +: 8] = (reqQ[i].size() != 0) ? reqQ[i][0][7:0] : 8'h00;
            reqLast[i] = (reqQ[i].size() != 0) ? reqQ[i][0][8] : 1'b0;
        end
        busy = randBusy ? ($urandom_range(2) == 0) : busyCmd;
        cyc++;
    endtask

    task automatic monitorCycle();
        int p;
        if (rst) begin
            pending = 1'b0;
        end else if (pending) begin
            chkEq("grant_owner", 32'(oOWNER), 32'(expOwner));
            chkEq("grant_vec", 32'(oGRANT), 32'(1 << expOwner));
            chkEq("grant_active", 32'(oACTIVE), 32'd1);
            grantLog.push_back(int'(oOWNER));
            grantCycle = cyc;
            modelLast = expOwner;
            pending = 1'b0;
            // A granted owner's whole next message must appear on the UART, uninterrupted.
            for (int j = 0; j < reqQ[expOwner].size(); j++) begin
                expQ.push_back(reqQ[expOwner][j][7:0]);
                if (reqQ[expOwner][j][8]) break;
            end
        end else if (!oACTIVE) begin
            p = rrPick(modelLast, reqValid);
            if (p >= 0) begin
                pending = 1'b1;
                expOwner = p;
            end
        end
        if (oUART_TX_REQ) begin
            wrCycles.push_back(cyc);
            if (expQ.size() == 0) chkEq("uart_unexpected_write", 32'(oUART_TX_DATA), 32'h100);
            else chkEq("uart_byte", 32'(oUART_TX_DATA), 32'(expQ.pop_front()));
        end
        chkEq("grant_onehot0", 32'($onehot0(oGRANT)), 32'd1);
        chkEq("ack_onehot0", 32'($onehot0(oREQ_ACK)), 32'd1);
        chkEq("wr_while_busy", 32'(oUART_TX_REQ & busy), 32'd0);
        chkEq("ack_without_valid", 32'(oREQ_ACK & ~reqValid), 32'd0);
        chkEq("ack_vs_write", 32'(|oREQ_ACK), 32'(oUART_TX_REQ));
        ackLatched = oREQ_ACK;
        for (int i = 0; i < c_N; i++) begin
            if (oREQ_ACK[i]) begin
                ackTotal[i]++;
                ackCycle[i] = cyc;
            end
        end
        if (oTIMEOUT) begin
            timeoutCount++;
            timeoutCycle = cyc;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            driveInputs();
            @(negedge clk);
            monitorCycle();
        end
    end

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while ((anyQueued() || expQ.size() != 0 || pending || oACTIVE) && n < budget) begin
            tick();
            n++;
        end
        chkEq({tag, "_completes"}, 32'(n < budget), 32'd1);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        for (int i = 0; i < c_N; i++) reqQ[i].delete();
        tick();
        tick();
        expQ.delete();
        modelLast = c_N - 1;
        rst = 1'b0;
    endtask

    initial begin
        int loadCyc;
        int n;
        int base;
        int to0;
        int totalBytes;
        int len;
        logic [7:0] b;
        int order [5] = '{0, 1, 2, 3, 0};

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        chkEq("rst_grant", 32'(oGRANT), 32'd0);
        chkEq("rst_ack", 32'(oREQ_ACK), 32'd0);
        chkEq("rst_txreq", 32'(oUART_TX_REQ), 32'd0);
        chkEq("rst_txdata", 32'(oUART_TX_DATA), 32'd0);
        chkEq("rst_active", 32'(oACTIVE), 32'd0);
        chkEq("rst_timeout", 32'(oTIMEOUT), 32'd0);
        chkEq("rst_owner", 32'(oOWNER), 32'd3);
        tick();
        rst = 1'b0;
        tick();

        // 1: single three-byte message from requester 0
        wrCycles.delete();
        loadCyc = cyc;
        loadMsg(0, 3, 8'h41);
        waitDone("t1", 50);
        chkEq("t1_writes", 32'(wrCycles.size()), 32'd3);
        if (wrCycles.size() == 3) begin
            chkEq("t1_first_write_cycle", 32'(wrCycles[0]), 32'(loadCyc + 2));
            chkEq("t1_last_write_cycle", 32'(wrCycles[2]), 32'(loadCyc + 4));
        end
        chkEq("t1_owner_kept", 32'(oOWNER), 32'd0);
        chkEq("t1_idle", 32'(oACTIVE), 32'd0);

        // 2: all requesters busy with two-byte messages, fresh from reset
        resetDut();
        grantLog.delete();
        wrCycles.delete();
        loadMsg(0, 2, 8'h10);
        loadMsg(0, 2, 8'h12);
        loadMsg(1, 2, 8'h20);
        loadMsg(2, 2, 8'h30);
        loadMsg(3, 2, 8'h40);
        waitDone("t2", 100);
        chkEq("t2_grants", 32'(grantLog.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grantLog.size()) chkEq("t2_grant_order", 32'(grantLog[i]), 32'(order[i]));
        end
        chkEq("t2_writes", 32'(wrCycles.size()), 32'd10);

        // 3: owner stalled by a full FIFO must not time out
        busyCmd = 1'b1;
        loadMsg(2, 1, 8'h77);
        n = 0;
        while (!(oACTIVE && oOWNER == 2'd2) && n < 20) begin
            tick();
            n++;
        end
        chkEq("t3_granted", 32'(n < 20), 32'd1);
        wrCycles.delete();
        to0 = timeoutCount;
        repeat (50) tick();
        chkEq("t3_no_write_busy", 32'(wrCycles.size()), 32'd0);
        chkEq("t3_no_timeout", 32'(timeoutCount), 32'(to0));
        chkEq("t3_still_active", 32'(oACTIVE), 32'd1);
        busyCmd = 1'b0;
        tick();
        @(negedge clk);
        chkEq("t3_ack_on_release", 32'(oREQ_ACK), 32'h4);
        chkEq("t3_write_on_release", 32'(oUART_TX_REQ), 32'd1);
        chkEq("t3_data_on_release", 32'(oUART_TX_DATA), 32'h77);
        waitDone("t3", 20);

        // 4: requester 1 stops mid-message; released after the timeout
        grantLog.delete();
        to0 = timeoutCount;
        base = ackTotal[1];
        reqQ[1].push_back({1'b0, 8'h5A});
        n = 0;
        while (ackTotal[1] == base && n < 20) begin
            tick();
            n++;
        end
        chkEq("t4_first_accept", 32'(n < 20), 32'd1);
        repeat (3) tick();
        loadMsg(3, 1, 8'h3C);
        n = 0;
        while (timeoutCount == to0 && n < 100) begin
            tick();
            n++;
        end
        chkEq("t4_timeout_seen", 32'(n < 100), 32'd1);
        waitDone("t4", 50);
        chkEq("t4_timeout_delay", 32'(timeoutCycle - ackCycle[1]), 32'd16);
        chkEq("t4_timeout_pulses", 32'(timeoutCount - to0), 32'd1);
        chkEq("t4_regrant_delay", 32'(grantCycle - timeoutCycle), 32'd1);
        chkEq("t4_grants", 32'(grantLog.size()), 32'd2);
        if (grantLog.size() == 2) chkEq("t4_next_owner", 32'(grantLog[1]), 32'd3);

        // 5: reset in the middle of a requester-1 message
        base = ackTotal[1];
        loadMsg(1, 4, 8'h50);
        n = 0;
        while (ackTotal[1] < base + 2 && n < 50) begin
            tick();
            n++;
        end
        chkEq("t5_mid_message", 32'(n < 50), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < c_N; i++) reqQ[i].delete();
        tick();
        rst = 1'b0;
        expQ.delete();
        modelLast = c_N - 1;
        grantLog.delete();
        loadMsg(1, 1, 8'h60);
        loadMsg(0, 1, 8'h61);
        @(negedge clk);
        chkEq("t5_grant_dropped", 32'(oGRANT), 32'd0);
        chkEq("t5_no_write", 32'(oUART_TX_REQ), 32'd0);
        waitDone("t5", 50);
        chkEq("t5_grants", 32'(grantLog.size()), 32'd2);
        if (grantLog.size() == 2) begin
            chkEq("t5_first_owner", 32'(grantLog[0]), 32'd0);
            chkEq("t5_second_owner", 32'(grantLog[1]), 32'd1);
        end

        // 6: random gaps and FIFO backpressure, scoreboard checks stream order
        wrCycles.delete();
        totalBytes = 0;
        for (int m = 0; m < 3; m++) begin
            for (int r = 0; r < c_N; r++) begin
                len = $urandom_range(4, 1);
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(255));
                    reqQ[r].push_back({(k == len - 1) ? 1'b1 : 1'b0, b});
                end
                totalBytes += len;
            end
        end
        randGaps = 1'b1;
        randBusy = 1'b1;
        waitDone("t6", 3000);
        randGaps = 1'b0;
        randBusy = 1'b0;
        tick();
        chkEq("t6_write_count", 32'(wrCycles.size()), 32'(totalBytes));
        chkEq("t6_no_timeouts", 32'(timeoutCount), 32'd1);
        chkEq("end_scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
